// File: rtl/seg_pkg.sv
// Shared types, display codes and the pattern decoder for the seven-segment
// loopback receiver.
package seg_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        OFFER  = 2'd1,
        HOLD   = 2'd2
    } seg_state_e;

    // Bit 7 is the sign segment, bits 6:0 are segments g..a.
    localparam logic [7:0] SEG_P0    = 8'h3F;
    localparam logic [7:0] SEG_P1    = 8'h06;
    localparam logic [7:0] SEG_P2    = 8'h5B;
    localparam logic [7:0] SEG_P3    = 8'h4F;
    localparam logic [7:0] SEG_M1    = 8'h86;
    localparam logic [7:0] SEG_M2    = 8'hDB;
    localparam logic [7:0] SEG_M3    = 8'hCF;
    localparam logic [7:0] SEG_M4    = 8'hE6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef struct packed {
        logic       legal;
        logic       is_blank;
        logic [2:0] value;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [7:0] seg);
        seg_dec_t d;
        d.legal    = 1'b1;
        d.is_blank = 1'b0;
        d.value    = 3'b000;
        case (seg)
            SEG_P0:    d.value = 3'b000;
            SEG_P1:    d.value = 3'b001;
            SEG_P2:    d.value = 3'b010;
            SEG_P3:    d.value = 3'b011;
            SEG_M1:    d.value = 3'b111;
            SEG_M2:    d.value = 3'b110;
            SEG_M3:    d.value = 3'b101;
            SEG_M4:    d.value = 3'b100;
            SEG_BLANK: begin
                d.legal    = 1'b0;
                d.is_blank = 1'b1;
            end
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_display_decoder_if.sv
// Display bus observation plus the downstream valid/ready channel and the
// event counters of the loopback receiver.
interface seg_display_decoder_if #(
    parameter int NBITS_SEG = 8,
    parameter int NBITS_CNT = 8
);
    logic [NBITS_SEG-1:0] seg_in;
    logic                 out_ready;
    logic                 out_valid;
    logic [2:0]           out_value;
    logic                 err_pulse;
    logic [NBITS_CNT-1:0] err_count;
    logic [NBITS_CNT-1:0] dec_count;

    // Board / checker side: drives the display pattern and the ready.
    modport master (
        output seg_in,
        output out_ready,
        input  out_valid,
        input  out_value,
        input  err_pulse,
        input  err_count,
        input  dec_count
    );

    // Decoder side.
    modport slave (
        input  seg_in,
        input  out_ready,
        output out_valid,
        output out_value,
        output err_pulse,
        output err_count,
        output dec_count
    );
endinterface

// File: rtl/seg_stability_filter.sv
// Registers the display bus and reports when the registered pattern has held
// unchanged for STABLE_CYCLES consecutive edges.
module seg_stability_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_SEG     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic [NBITS_SEG-1:0] seg_q,
    output logic                 stable
);
    localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

    logic [7:0] stab_cnt;

    // Count saturates at the target so stable stays high while the pattern holds.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            seg_q    <= '0;
            stab_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STABLE_TGT) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    assign stable = (stab_cnt == STABLE_TGT);

endmodule

// File: rtl/seg_display_decoder.sv
// Loopback receiver for the signed 3-bit display bus: filters, decodes and
// offers each new stable pattern once, counting illegal patterns.
module seg_display_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_SEG     = 8,
    parameter int NBITS_CNT     = 8
) (
    input logic                  clk_2,
    input logic                  reset,
    seg_display_decoder_if.slave bus
);
    logic [NBITS_SEG-1:0] seg_q;
    logic                 stable;
    logic [NBITS_SEG-1:0] cap_seg;
    seg_state_e           state;

    logic                 out_valid_reg;
    logic [2:0]           out_value_reg;
    logic                 err_pulse_reg;
    logic [NBITS_CNT-1:0] err_count_reg;
    logic [NBITS_CNT-1:0] dec_count_reg;

    seg_dec_t             dec;
    logic                 upper_clear;
    logic                 pat_legal;
    logic                 pat_blank;

    seg_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .NBITS_SEG     (NBITS_SEG)
    ) u_filter (
        .clk_2  (clk_2),
        .reset  (reset),
        .seg_in (bus.seg_in),
        .seg_q  (seg_q),
        .stable (stable)
    );

    // Any lit segment above the 8-bit display code makes the pattern illegal.
    generate
        if (NBITS_SEG > 8) begin : g_wide
            assign upper_clear = ~|seg_q[NBITS_SEG-1:8];
        end else begin : g_narrow
            assign upper_clear = 1'b1;
        end
    endgenerate

    assign dec       = seg_decode(seg_q[7:0]);
    assign pat_legal = dec.legal & upper_clear;
    assign pat_blank = dec.is_blank & upper_clear;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state         <= SETTLE;
            cap_seg       <= '0;
            out_valid_reg <= 1'b0;
            out_value_reg <= 3'b000;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            dec_count_reg <= '0;
        end else begin
            err_pulse_reg <= 1'b0;
            case (state)
                SETTLE: begin
                    if (stable) begin
                        cap_seg <= seg_q;
                        // A pattern that settles back to the captured one
                        // (e.g. after a short glitch) is not decoded again.
                        if (seg_q == cap_seg) begin
                            state <= HOLD;
                        end else if (pat_legal) begin
                            out_value_reg <= dec.value;
                            out_valid_reg <= 1'b1;
                            state         <= OFFER;
                        end else if (pat_blank) begin
                            state <= HOLD;
                        end else begin
                            err_pulse_reg <= 1'b1;
                            if (err_count_reg != '1) begin
                                err_count_reg <= err_count_reg + NBITS_CNT'(1);
                            end
                            state <= HOLD;
                        end
                    end
                end
                OFFER: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        dec_count_reg <= dec_count_reg + NBITS_CNT'(1);
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (seg_q != cap_seg) begin
                        state <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_value = out_value_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.err_count = err_count_reg;
    assign bus.dec_count = dec_count_reg;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: a vector table of single patterns
// followed by hand-written multi-cycle sequences.
module tb_seg_display_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seg_display_decoder_if #(.NBITS_SEG(8), .NBITS_CNT(8)) bus ();

    seg_display_decoder #(
        .STABLE_CYCLES (4),
        .NBITS_SEG     (8),
        .NBITS_CNT     (8)
    ) dut (
        .clk_2 (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        int         exp_valid;
        logic [2:0] exp_val;
        int         exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one pattern for n edges, sampling outputs on each following negedge.
    task automatic apply(input logic [7:0] seg, input logic rdy, input int n,
                         input logic [2:0] exp_val,
                         output int first_valid, output int valid_cnt,
                         output int bad_val, output logic [2:0] last_val,
                         output int err_cnt, output int first_err);
        bus.seg_in    = seg;
        bus.out_ready = rdy;
        first_valid = -1; valid_cnt = 0; bad_val = 0; last_val = 3'b000;
        err_cnt = 0; first_err = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = k;
                valid_cnt++;
                last_val = bus.out_value;
                if (bus.out_value != exp_val) bad_val++;
            end
            if (bus.err_pulse) begin
                if (first_err < 0) first_err = k;
                err_cnt++;
            end
        end
        $display("apply seg=%02h rdy=%0d n=%0d: valid_cnt=%0d first_valid=%0d val=%0d err_cnt=%0d dec=%0d errc=%0d",
                 seg, rdy, n, valid_cnt, first_valid, last_val, err_cnt,
                 bus.dec_count, bus.err_count);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.seg_in    = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int fv, vc, bv, ec, fe;
        logic [2:0] lv;
        logic [7:0] pat;

        checks = 0;
        errors = 0;

        tbl[0]  = '{8'h4F, 1, 3'b011, 0};
        tbl[1]  = '{8'h3F, 1, 3'b000, 0};
        tbl[2]  = '{8'h06, 1, 3'b001, 0};
        tbl[3]  = '{8'h5B, 1, 3'b010, 0};
        tbl[4]  = '{8'h86, 1, 3'b111, 0};
        tbl[5]  = '{8'hDB, 1, 3'b110, 0};
        tbl[6]  = '{8'hCF, 1, 3'b101, 0};
        tbl[7]  = '{8'hE6, 1, 3'b100, 0};
        tbl[8]  = '{8'h7F, 0, 3'b000, 1};
        tbl[9]  = '{8'h00, 0, 3'b000, 0};
        tbl[10] = '{8'h12, 0, 3'b000, 1};
        tbl[11] = '{8'h3F, 1, 3'b000, 0};

        do_reset();
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_value", int'(bus.out_value), 0);
        chk("rst_err_pulse", int'(bus.err_pulse), 0);
        chk("rst_err_count", int'(bus.err_count), 0);
        chk("rst_dec_count", int'(bus.dec_count), 0);

        // Table: each pattern held 10 edges with ready high.
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].seg, 1'b1, 10, tbl[i].exp_val, fv, vc, bv, lv, ec, fe);
            chk($sformatf("tbl%0d_valid_cnt", i), vc, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_value", i), bv, 0);
            chk($sformatf("tbl%0d_err_cnt", i), ec, tbl[i].exp_err);
            if (tbl[i].exp_valid > 0) chk($sformatf("tbl%0d_valid_lat", i), fv, 6);
            if (tbl[i].exp_err > 0)   chk($sformatf("tbl%0d_err_lat", i), fe, 6);
            if (i == 0) chk("tbl0_dec_count", int'(bus.dec_count), 1);
        end
        chk("tbl_dec_total", int'(bus.dec_count), 9);
        chk("tbl_err_total", int'(bus.err_count), 2);

        // Offer held against a stalled consumer, then released.
        do_reset();
        apply(8'hE6, 1'b0, 20, 3'b100, fv, vc, bv, lv, ec, fe);
        chk("stall_valid_lat", fv, 6);
        chk("stall_valid_cnt", vc, 15);
        chk("stall_value_bad", bv, 0);
        apply(8'hE6, 1'b1, 1, 3'b100, fv, vc, bv, lv, ec, fe);
        chk("stall_drop", vc, 0);
        chk("stall_dec_count", int'(bus.dec_count), 1);

        // Short glitch between two identical patterns.
        apply(8'h3F, 1'b1, 10, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("glitch_first_decode", vc, 1);
        chk("glitch_first_value", int'(lv), 0);
        apply(8'h06, 1'b1, 2, 3'b001, fv, vc, bv, lv, ec, fe);
        chk("glitch_pulse_valid", vc, 0);
        chk("glitch_pulse_err", ec, 0);
        apply(8'h3F, 1'b1, 10, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("glitch_return_valid", vc, 0);
        chk("glitch_return_err", ec, 0);
        chk("glitch_dec_count", int'(bus.dec_count), 2);

        // Illegal, blank, illegal; then drive the counter into saturation.
        do_reset();
        apply(8'h7F, 1'b1, 8, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("ill1_err", ec, 1);
        chk("ill1_valid", vc, 0);
        apply(8'h00, 1'b1, 8, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("blank_err", ec, 0);
        chk("blank_valid", vc, 0);
        apply(8'h7F, 1'b1, 8, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("ill2_err", ec, 1);
        chk("ill2_valid", vc, 0);
        chk("ill_err_count", int'(bus.err_count), 2);
        for (int i = 0; i < 253; i++) begin
            pat = (i % 2 == 0) ? 8'h7E : 8'h7F;
            apply(pat, 1'b1, 8, 3'b000, fv, vc, bv, lv, ec, fe);
        end
        chk("sat_reach", int'(bus.err_count), 255);
        apply(8'h7F, 1'b1, 8, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("sat_pulse", ec, 1);
        chk("sat_hold", int'(bus.err_count), 255);

        // New pattern arriving while a value is being offered.
        do_reset();
        apply(8'h5B, 1'b0, 10, 3'b010, fv, vc, bv, lv, ec, fe);
        chk("ovl_first_cnt", vc, 5);
        apply(8'hCF, 1'b0, 10, 3'b010, fv, vc, bv, lv, ec, fe);
        chk("ovl_held_cnt", vc, 10);
        chk("ovl_held_bad", bv, 0);
        apply(8'hCF, 1'b1, 1, 3'b010, fv, vc, bv, lv, ec, fe);
        chk("ovl_hs1_drop", vc, 0);
        chk("ovl_hs1_dec", int'(bus.dec_count), 1);
        apply(8'hCF, 1'b0, 4, 3'b101, fv, vc, bv, lv, ec, fe);
        chk("ovl_second_lat", fv, 2);
        chk("ovl_second_value", int'(lv), 5);
        apply(8'hCF, 1'b1, 1, 3'b101, fv, vc, bv, lv, ec, fe);
        chk("ovl_hs2_dec", int'(bus.dec_count), 2);

        // Ready and a pattern change on the same edge.
        apply(8'h4F, 1'b0, 8, 3'b011, fv, vc, bv, lv, ec, fe);
        chk("sim_offer_lat", fv, 6);
        apply(8'h06, 1'b1, 10, 3'b001, fv, vc, bv, lv, ec, fe);
        chk("sim_new_cnt", vc, 1);
        chk("sim_new_lat", fv, 6);
        chk("sim_new_value", int'(lv), 1);
        chk("sim_dec_count", int'(bus.dec_count), 4);

        // Reset in the middle of an offer.
        apply(8'h5B, 1'b0, 10, 3'b010, fv, vc, bv, lv, ec, fe);
        chk("mid_offer_valid", int'(bus.out_valid), 1);
        reset         = 1'b1;
        bus.seg_in    = 8'h00;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_value", int'(bus.out_value), 0);
        chk("mid_rst_dec", int'(bus.dec_count), 0);
        chk("mid_rst_errc", int'(bus.err_count), 0);
        reset = 1'b0;
        apply(8'h00, 1'b1, 12, 3'b000, fv, vc, bv, lv, ec, fe);
        chk("post_rst_blank_valid", vc, 0);
        chk("post_rst_blank_err", ec, 0);
        chk("post_rst_blank_dec", int'(bus.dec_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
